// File: rtl/memory_port_arbiter_if.sv
// Requester-side handshake bundle for memory_port_arbiter: one instance per master (m0, m1).
// The master drives the command; the arbiter returns grant, completion, read data and error.
interface memory_port_arbiter_if #(
    parameter int W = 32
) ();
    logic         req;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         gnt;
    logic         rvalid;
    logic [W-1:0] rdata;
    logic         err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Two-master arbiter for memory port 2 (IDLE/ACCESS FSM, fixed priority with m1 starvation bound).
// Define MEMORY_ARBITER_ROUND_ROBIN_EN to replace the starvation counter with alternating priority.
module memory_port_arbiter #(
    parameter  int WORD_SIZE_BYTES = 4,
    parameter  int HOLD_MAX        = 4,
    localparam int W               = WORD_SIZE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memory_port_arbiter_if.slave  m0,
    memory_port_arbiter_if.slave  m1,
    output logic                  memory_write_enable2,
    output logic [W-1:0]          memory_address2,
    inout  wire  [W-1:0]          memory_data2
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t       state;
    logic         lat_id;      // 1 = current access belongs to m1
    logic [W-1:0] lat_wdata;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic         rr_ptr;      // 1 = m1 has priority on the next contested grant
`else
    logic [3:0]   starve_cnt;
`endif

    logic         any_req;
    logic         pick_m1;
    logic         win_we;
    logic [W-1:0] win_addr;
    logic [W-1:0] win_wdata;
    logic         win_misaligned;

    always_comb begin
        any_req = m0.req | m1.req;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        pick_m1 = m1.req & (~m0.req | rr_ptr);
`else
        pick_m1 = m1.req & (~m0.req | (starve_cnt == 4'(HOLD_MAX)));
`endif
        win_we         = pick_m1 ? m1.we    : m0.we;
        win_addr       = pick_m1 ? m1.addr  : m0.addr;
        win_wdata      = pick_m1 ? m1.wdata : m0.wdata;
        win_misaligned = |win_addr[1:0];
    end

    // NOTE: the arbiter only drives the shared data bus while its own write is on the pins;
    // at all other times the memory owns it.
    assign memory_data2 = memory_write_enable2 ? lat_wdata : 'z;

    // NOTE: reset is synchronous, so it lives inside the clocked block; all state uses <=.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= IDLE;
            lat_id               <= 1'b0;
            lat_wdata            <= '0;
            memory_write_enable2 <= 1'b0;
            memory_address2      <= '0;
            m0.gnt               <= 1'b0;
            m0.rvalid            <= 1'b0;
            m0.err               <= 1'b0;
            m0.rdata             <= '0;
            m1.gnt               <= 1'b0;
            m1.rvalid            <= 1'b0;
            m1.err               <= 1'b0;
            m1.rdata             <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            rr_ptr               <= 1'b0;
`else
            starve_cnt           <= '0;
`endif
        end else begin
            m0.gnt    <= 1'b0;
            m0.rvalid <= 1'b0;
            m0.err    <= 1'b0;
            m1.gnt    <= 1'b0;
            m1.rvalid <= 1'b0;
            m1.err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        if (win_misaligned) begin
                            // Rejected command: no access and no change to fairness state.
                            if (pick_m1) m1.err <= 1'b1;
                            else         m0.err <= 1'b1;
                        end else begin
                            state                <= ACCESS;
                            lat_id               <= pick_m1;
                            lat_wdata            <= win_wdata;
                            memory_address2      <= win_addr;
                            memory_write_enable2 <= win_we;
                            if (pick_m1) m1.gnt <= 1'b1;
                            else         m0.gnt <= 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                            rr_ptr <= ~pick_m1;
`else
                            if (pick_m1 || !m1.req) starve_cnt <= '0;
                            else                    starve_cnt <= starve_cnt + 4'd1;
`endif
                        end
                    end
                end

                ACCESS: begin
                    state                <= IDLE;
                    memory_write_enable2 <= 1'b0;
                    if (lat_id) begin
                        m1.rvalid <= 1'b1;
                        if (!memory_write_enable2) m1.rdata <= memory_data2;
                    end else begin
                        m0.rvalid <= 1'b1;
                        if (!memory_write_enable2) m0.rdata <= memory_data2;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
